smc_input_loader: RTL and testbench

- Upstream feeder for the SMC transistor-current block.
- Accepts transistor parameter sets one per beat over a valid/ready stream and assembles six beats into one frame.
- Presents each frame to SMC as stable parallel registered operands (mode, W_0..W_5, V_GS_0..V_GS_5, V_DS_0..V_DS_5) and qualifies it with a one-cycle Enable pulse.
- Holds the operands stable for a programmable settle window so SMC's out_n can be sampled downstream.

---
 rtl/smc_input_loader.sv | 171 +++++++++++++++++
 tb/tb_smc_input_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/smc_input_loader.sv
// smc_input_loader
//   Upstream feeder for the SMC transistor-current block. Collects six
//   parameter beats (W, V_GS, V_DS) over a valid/ready stream into shadow
//   registers, then issues them as one frame of registered parallel operands
//   qualified by a one-cycle Enable pulse. After the issue the operands stay
//   frozen and in_ready stays low for HOLD_CYC cycles.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : beat handshake (in_ready is registered)
//   in_mode             : frame mode, taken from beat 0 only
//   in_w/in_vgs/in_vds  : per-beat transistor parameters
//   in_last             : marks beat 5
//   mode, W_*, V_GS_*, V_DS_* : registered operands to SMC
//   Enable              : one-cycle pulse, new frame on the operands
//   frame_err           : one-cycle pulse, misframed input discarded
module smc_input_loader #(
   parameter int P_W      = 3,
   parameter int P_MODE   = 2,
   parameter int HOLD_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [P_MODE-1:0] in_mode,
   input  logic [P_W-1:0]    in_w,
   input  logic [P_W-1:0]    in_vgs,
   input  logic [P_W-1:0]    in_vds,
   input  logic              in_last,
   output logic [P_MODE-1:0] mode,
   output logic [P_W-1:0]    W_0,
   output logic [P_W-1:0]    W_1,
   output logic [P_W-1:0]    W_2,
   output logic [P_W-1:0]    W_3,
   output logic [P_W-1:0]    W_4,
   output logic [P_W-1:0]    W_5,
   output logic [P_W-1:0]    V_GS_0,
   output logic [P_W-1:0]    V_GS_1,
   output logic [P_W-1:0]    V_GS_2,
   output logic [P_W-1:0]    V_GS_3,
   output logic [P_W-1:0]    V_GS_4,
   output logic [P_W-1:0]    V_GS_5,
   output logic [P_W-1:0]    V_DS_0,
   output logic [P_W-1:0]    V_DS_1,
   output logic [P_W-1:0]    V_DS_2,
   output logic [P_W-1:0]    V_DS_3,
   output logic [P_W-1:0]    V_DS_4,
   output logic [P_W-1:0]    V_DS_5,
   output logic              Enable,
   output logic              frame_err
);

   typedef enum logic [1:0] {COLLECT, ISSUE, HOLD} state_t;

   // HOLD lasts HOLD_CYC cycles: the counter runs HOLD_CYC-1 down to 0.
   localparam logic [3:0] HOLD_LOAD = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

   state_t state, state_nxt;
   logic [2:0] beat_cnt, beat_cnt_nxt;
   logic [3:0] hold_cnt, hold_cnt_nxt;
   logic       xfer, at_last, good_frame, bad_frame;

   logic [P_MODE-1:0]     sh_mode;
   logic [5:0][P_W-1:0]   sh_w, sh_vgs, sh_vds;
   logic [5:0][P_W-1:0]   out_w, out_vgs, out_vds;

   always_comb begin
      xfer         = in_valid && in_ready && (state == COLLECT);
      at_last      = (beat_cnt == 3'd5);
      good_frame   = xfer && at_last && in_last;
      bad_frame    = xfer && (in_last != at_last);
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      hold_cnt_nxt = hold_cnt;
      case (state)
         COLLECT: begin
            if (good_frame) begin
               state_nxt    = ISSUE;
               beat_cnt_nxt = '0;
            end else if (bad_frame) begin
               beat_cnt_nxt = '0;
            end else if (xfer) begin
               beat_cnt_nxt = beat_cnt + 3'd1;
            end
         end
         ISSUE: begin
            if (HOLD_CYC == 0) begin
               state_nxt = COLLECT;
            end else begin
               state_nxt    = HOLD;
               hold_cnt_nxt = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (hold_cnt == '0) state_nxt = COLLECT;
            else                hold_cnt_nxt = hold_cnt - 4'd1;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= COLLECT;
         beat_cnt  <= '0;
         hold_cnt  <= '0;
         in_ready  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         beat_cnt  <= beat_cnt_nxt;
         hold_cnt  <= hold_cnt_nxt;
         in_ready  <= (state_nxt == COLLECT);
         frame_err <= bad_frame;
      end
   end

   // The operand registers load on the edge that enters ISSUE so they change
   // together with Enable; slot 5 is taken straight from the inputs because
   // its shadow slot is being written on that same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_mode <= '0;
         sh_w    <= '0;
         sh_vgs  <= '0;
         sh_vds  <= '0;
         mode    <= '0;
         out_w   <= '0;
         out_vgs <= '0;
         out_vds <= '0;
      end else begin
         if (xfer) begin
            sh_w[beat_cnt]   <= in_w;
            sh_vgs[beat_cnt] <= in_vgs;
            sh_vds[beat_cnt] <= in_vds;
            if (beat_cnt == 3'd0) sh_mode <= in_mode;
         end
         if (good_frame) begin
            mode         <= sh_mode;
            out_w[4:0]   <= sh_w[4:0];
            out_vgs[4:0] <= sh_vgs[4:0];
            out_vds[4:0] <= sh_vds[4:0];
            out_w[5]     <= in_w;
            out_vgs[5]   <= in_vgs;
            out_vds[5]   <= in_vds;
         end
      end
   end

   assign Enable = (state == ISSUE);

   assign W_0 = out_w[0];
   assign W_1 = out_w[1];
   assign W_2 = out_w[2];
   assign W_3 = out_w[3];
   assign W_4 = out_w[4];
   assign W_5 = out_w[5];
   assign V_GS_0 = out_vgs[0];
   assign V_GS_1 = out_vgs[1];
   assign V_GS_2 = out_vgs[2];
   assign V_GS_3 = out_vgs[3];
   assign V_GS_4 = out_vgs[4];
   assign V_GS_5 = out_vgs[5];
   assign V_DS_0 = out_vds[0];
   assign V_DS_1 = out_vds[1];
   assign V_DS_2 = out_vds[2];
   assign V_DS_3 = out_vds[3];
   assign V_DS_4 = out_vds[4];
   assign V_DS_5 = out_vds[5];

endmodule

// File: tb/tb_smc_input_loader.sv
// Scoreboard bench for smc_input_loader. Instance A uses HOLD_CYC=2,
// instance B uses HOLD_CYC=0 for the back-to-back frame case.
module tb_smc_input_loader;

   typedef struct packed {
      logic            err;
      logic [1:0]      m;
      logic [5:0][2:0] w;
      logic [5:0][2:0] g;
      logic [5:0][2:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic a_valid = 1'b0, a_last = 1'b0, a_ready, a_en, a_err;
   logic [1:0] a_mode_i = '0, a_mode;
   logic [2:0] a_w = '0, a_vgs = '0, a_vds = '0;
   logic [5:0][2:0] aw, ag, ad;

   logic b_valid = 1'b0, b_last = 1'b0, b_ready, b_en, b_err;
   logic [1:0] b_mode_i = '0, b_mode;
   logic [2:0] b_w = '0, b_vgs = '0, b_vds = '0;
   logic [5:0][2:0] bw, bg, bd;

   exp_t qa[$];
   exp_t qb[$];
   exp_t cur_a = '0;
   exp_t cur_b = '0;
   int   b_t[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   smc_input_loader #(.P_W(3), .P_MODE(2), .HOLD_CYC(2)) dut_a (
      .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
      .in_mode(a_mode_i), .in_w(a_w), .in_vgs(a_vgs), .in_vds(a_vds), .in_last(a_last),
      .mode(a_mode),
      .W_0(aw[0]), .W_1(aw[1]), .W_2(aw[2]), .W_3(aw[3]), .W_4(aw[4]), .W_5(aw[5]),
      .V_GS_0(ag[0]), .V_GS_1(ag[1]), .V_GS_2(ag[2]), .V_GS_3(ag[3]), .V_GS_4(ag[4]), .V_GS_5(ag[5]),
      .V_DS_0(ad[0]), .V_DS_1(ad[1]), .V_DS_2(ad[2]), .V_DS_3(ad[3]), .V_DS_4(ad[4]), .V_DS_5(ad[5]),
      .Enable(a_en), .frame_err(a_err));

   smc_input_loader #(.P_W(3), .P_MODE(2), .HOLD_CYC(0)) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
      .in_mode(b_mode_i), .in_w(b_w), .in_vgs(b_vgs), .in_vds(b_vds), .in_last(b_last),
      .mode(b_mode),
      .W_0(bw[0]), .W_1(bw[1]), .W_2(bw[2]), .W_3(bw[3]), .W_4(bw[4]), .W_5(bw[5]),
      .V_GS_0(bg[0]), .V_GS_1(bg[1]), .V_GS_2(bg[2]), .V_GS_3(bg[3]), .V_GS_4(bg[4]), .V_GS_5(bg[5]),
      .V_DS_0(bd[0]), .V_DS_1(bd[1]), .V_DS_2(bd[2]), .V_DS_3(bd[3]), .V_DS_4(bd[4]), .V_DS_5(bd[5]),
      .Enable(b_en), .frame_err(b_err));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t act_of(input int d);
      exp_t r;
      r.err = 1'b0;
      r.m = (d == 0) ? a_mode : b_mode;
      r.w = (d == 0) ? aw : bw;
      r.g = (d == 0) ? ag : bg;
      r.d = (d == 0) ? ad : bd;
      return r;
   endfunction

   // Monitors: pop on Enable / frame_err, otherwise operands must hold.
   always @(negedge clk) begin
      exp_t e;
      if (reset) cur_a = '0;
      else begin
         check("a_en_err_exclusive", 64'(a_en && a_err), 64'd0);
         if (a_en || a_err) begin
            if (qa.size() == 0) check("a_unexpected_event", {a_en, a_err}, 64'd0);
            else begin
               e = qa.pop_front();
               check("a_event_kind", {a_en, a_err}, e.err ? 64'd1 : 64'd2);
               if (a_en) begin
                  check("a_issue_ops", act_of(0), e);
                  cur_a = e;
               end else check("a_err_keeps_ops", act_of(0), cur_a);
            end
         end else check("a_stable_ops", act_of(0), cur_a);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset) cur_b = '0;
      else begin
         check("b_en_err_exclusive", 64'(b_en && b_err), 64'd0);
         if (b_en || b_err) begin
            if (qb.size() == 0) check("b_unexpected_event", {b_en, b_err}, 64'd0);
            else begin
               e = qb.pop_front();
               check("b_event_kind", {b_en, b_err}, e.err ? 64'd1 : 64'd2);
               if (b_en) begin
                  check("b_issue_ops", act_of(1), e);
                  cur_b = e;
                  b_t.push_back(cyc);
               end else check("b_err_keeps_ops", act_of(1), cur_b);
            end
         end else check("b_stable_ops", act_of(1), cur_b);
      end
   end

   task automatic drive(input int d, input logic v, input logic [1:0] m, input logic [2:0] w,
                        input logic [2:0] g, input logic [2:0] x, input logic l);
      if (d == 0) begin
         a_valid = v; a_mode_i = m; a_w = w; a_vgs = g; a_vds = x; a_last = l;
      end else begin
         b_valid = v; b_mode_i = m; b_w = w; b_vgs = g; b_vds = x; b_last = l;
      end
   endtask

   // kind: 0 = no event expected, 1 = issue, 2 = frame error
   task automatic send(input int d, input exp_t f, input int nb, input int last_at,
                       input int gap, input int kind);
      exp_t er;
      int n;
      er = '0;
      er.err = 1'b1;
      if (kind == 1) begin if (d == 0) qa.push_back(f); else qb.push_back(f); end
      if (kind == 2) begin if (d == 0) qa.push_back(er); else qb.push_back(er); end
      for (int k = 0; k < nb; k++) begin
         // mode is scrambled on non-zero beats: only beat 0 may be captured
         drive(d, 1'b1, (k == 0) ? f.m : ~f.m, f.w[k], f.g[k], f.d[k], k == last_at);
         n = 0;
         @(negedge clk);
         while (!((d == 0) ? a_ready : b_ready) && n < 100) begin
            n++;
            @(negedge clk);
         end
         if (n >= 100) check("ready_timeout", 64'd0, 64'd1);
         @(posedge clk);
         #1;
         drive(d, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
         if (gap > 0 && k < nb - 1) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      if (kind == 1) check("enable_latency", (d == 0) ? a_en : b_en, 64'd1);
      if (kind == 2) begin
         check("err_latency", (d == 0) ? a_err : b_err, 64'd1);
         check("no_enable_on_err", (d == 0) ? a_en : b_en, 64'd0);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_a_ops"}, act_of(0), 64'd0);
      check({name, "_b_ops"}, act_of(1), 64'd0);
      check({name, "_flags"}, {a_en, a_err, a_ready, b_en, b_err, b_ready}, 64'd0);
   endtask

   exp_t f1, f2, f3;
   int   n;

   initial begin
      f1 = '0; f2 = '0; f3 = '0;
      f1.m = 2'b01; f2.m = 2'b10; f3.m = 2'b11;
      for (int k = 0; k < 6; k++) begin
         f1.w[k] = 3'(k + 1); f1.g[k] = 3'(7 - k); f1.d[k] = 3'(k);
         f2.w[k] = 3'(6 - k); f2.g[k] = 3'(k + 2); f2.d[k] = 3'(7 - k);
         f3.w[k] = (k % 2 == 1) ? 3'd7 : 3'd0; f3.g[k] = 3'd3; f3.d[k] = 3'(k + 2);
      end

      // power-on reset, released mid-cycle
      #2 check_reset_outputs("por");
      #10 reset = 1'b0;
      #1 check("ready_before_edge", a_ready, 64'd0);
      @(posedge clk); #1;
      check("ready_after_reset", {a_ready, b_ready}, 64'd3);

      // nominal frame, then count in_ready-low cycles
      send(0, f1, 6, 5, 0, 1);
      n = 0;
      while (!a_ready && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      check("ready_low_cycles", 64'(n), 64'd3);

      // asynchronous reset with a live frame on the outputs
      @(posedge clk); #2 reset = 1'b1;
      #1 check_reset_outputs("async_rst");
      #4 reset = 1'b0;
      @(posedge clk); #1;
      check("ready_after_async_rst", a_ready, 64'd1);

      send(0, f2, 6, 5, 1, 1);          // gapped input
      repeat (4) @(posedge clk); #1;
      send(0, f3, 4, 3, 0, 2);          // early in_last at beat 3
      send(0, f3, 6, 5, 0, 1);
      repeat (4) @(posedge clk); #1;
      send(0, f1, 6, -1, 0, 2);         // missing in_last at beat 5
      send(0, f2, 6, 5, 0, 1);          // restart from beat 0
      repeat (4) @(posedge clk); #1;

      // reset while beat 4 is pending
      send(0, f3, 4, -1, 0, 0);
      #3 reset = 1'b1;
      #5 reset = 1'b0;
      repeat (2) @(posedge clk); #1;
      send(0, f1, 6, 5, 0, 1);

      // back-to-back frames on the HOLD_CYC=0 instance
      send(1, f1, 6, 5, 0, 1);
      send(1, f2, 6, 5, 0, 1);
      repeat (3) @(posedge clk); #1;
      if (b_t.size() == 2) check("b2b_period", 64'(b_t[1] - b_t[0]), 64'd7);
      else check("b2b_enable_count", 64'(b_t.size()), 64'd2);

      repeat (5) @(posedge clk); #1;
      check("queues_drained", 64'(qa.size() + qb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
